uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Memory-mapped UART transmit controller for the Arty S7 board top, sitting on the iobus next to the program RAM. The CPU pushes bytes into a transmit FIFO with store instructions. An internal state machine sequences each byte onto `txd` as an 8N1 frame at a programmable baud divisor. Status and flags are readable over the same bus so firmware can poll before sending.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: default baud rate. Reset divisor = CLK_HZ/BAUD, rounded to nearest (434).
- `FIFO_DEPTH`, 16: transmit FIFO entries. Must be a power of 2, ≥2.

- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `addr` in 2: register select. 0 = DATA, 1 = STATUS, 2 = DIVISOR, 3 = reserved.
- `we` in 1: write strobe, sampled on rising `clk`.
- `wdata` in 32: write data.
- `rdata` out 32: read data. Combinational from `addr`; no read side effects.
- `txd` out 1: serial output. Registered; idles high.
- `irq` out 1: high while FIFO empty and FSM idle. Registered.

## Operation
- Write to DATA: pushes `wdata[7:0]`.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and sticky `overflow` is set.
  - A push and a pop in the same cycle are both honoured.
- STATUS read fields:
  - bit0 `busy`: FSM not IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `overflow`.
  - bits[8:4] `count` (0..FIFO_DEPTH).
  - All other bits 0.
- Writing STATUS with bit3=1 clears `overflow`. Other bits are ignored.
- DIVISOR holds 16 bits, giving cycles per bit.
  - Writes below 2 are clamped to 2.
  - Reads return the current value.
  - The divisor is latched into the FSM only at frame start, so a change never distorts a frame in flight.
- Reading DATA or reserved returns 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when FIFO is non-empty. On this transition: pop, load shift register, latch divisor, `txd`=0.
  - START → DATA after one bit time. `txd` = shift[0], bit index = 0.
  - DATA: every bit time, shift right and increment the index. After bit 7's period ends, go to STOP with `txd`=1.
  - STOP, after one bit time:
    - FIFO non-empty → START directly (pop, `txd`=0, no idle gap).
    - Otherwise → IDLE.
- Bit-time counter loads divisor−1 and counts down to 0. Each bit lasts exactly `divisor` cycles.

## Timing
- Reset values:
  - `txd`=1, `irq`=1.
  - FSM in IDLE, FIFO empty, `overflow`=0, divisor = CLK_HZ/BAUD.
  - `rdata` at STATUS reads 0x004.
- Write latency:
  - A DATA write sampled at edge E0 with the FIFO empty and FSM idle makes `count`=1 after E0.
  - The FSM pops at E1, so `txd` goes low after E1.
- Frame length: exactly 10×divisor cycles start-to-start when back-to-back.
- `busy` rises after E1 and falls one cycle after the stop bit ends (FIFO empty).
- `irq` deasserts with the edge that pushes into an empty FIFO. It reasserts on the edge where the FSM returns to IDLE.
- Reset mid-frame: `txd` returns high immediately (asynchronous) and the FIFO contents are discarded.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a count register, not pointer equality.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - register offsets `UART_DATA`, `UART_STATUS`, `UART_DIVISOR`;
  - status bit indices;
  - `UART_DIV_MIN`=2.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) with push/pop/full/empty/count, reusable for the later RX path.
- `uart_tx_ctrl` holds the register decode, divisor register, FSM, bit counter and shift register.

## Test plan
- Reset, then read STATUS → 0x004; `txd`=1; DIVISOR reads 434.
- Set DIVISOR=4, write DATA 0x55 → `txd` low for 4 cycles starting one cycle after the write edge, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop bit high 4 cycles; `busy`=0 and `irq`=1 afterwards.
- DIVISOR=4, write 0x41, 0x42, 0x43 consecutively → three frames back-to-back, 40 cycles apart, no idle gap; `count` reads 2, 1, 0 at each frame start.
- With the FSM stalled, write 17 bytes → 16 transmitted in order, `overflow`=1. Write STATUS 0x8 → `overflow`=0.
- Write DIVISOR=0 → reads 2. Write DIVISOR=8 mid-frame → the current frame keeps the old divisor and the next frame uses 8.
- Assert `reset` mid-DATA bit → `txd`=1 without waiting for `clk`; after release STATUS=0x004 and the queued bytes are never sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// The RX path will reuse this package.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_t;

    localparam logic [1:0] UART_DATA    = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 5;

    localparam logic [15:0] UART_DIV_MIN = 16'd2;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < UART_DIV_MIN) ? UART_DIV_MIN : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Full and empty come from an occupancy counter, so pointers
// simply wrap. A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage array has no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, divisor register,
// frame sequencer and shift register in front of a transmit FIFO.
module uart_tx_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);
    import uart_pkg::*;

    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] DIV_RESET = 16'((CLK_HZ + BAUD / 2) / BAUD);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]    div_lat_q, div_lat_d;
    logic [15:0]    div_q, div_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           txd_q, txd_d;
    logic           irq_q, irq_d;
    logic           overflow_q, overflow_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           bit_done;
    logic           start_frame;
    logic           unused_wdata_hi;

    assign fifo_push       = we && (addr == UART_DATA);
    assign bit_done        = (bit_cnt_q == '0);
    assign unused_wdata_hi = ^wdata[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (wdata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        // NOTE: every target is defaulted first so no path through the block infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_lat_d   = div_lat_q;
        div_d       = div_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        txd_d       = txd_q;
        overflow_d  = overflow_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: start_frame = !fifo_empty;
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    bit_cnt_d = div_lat_q - 16'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = div_lat_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) start_frame = 1'b1;
                    else             state_d     = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The divisor is captured only here, so bus writes never stretch a frame in flight.
        if (start_frame) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            div_lat_d = div_q;
            bit_cnt_d = div_q - 16'd1;
            txd_d     = 1'b0;
            state_d   = ST_START;
        end

        if (we && addr == UART_DIVISOR) begin
            div_d = clamp_div(wdata[15:0]);
        end

        if (we && addr == UART_STATUS && wdata[STAT_OVERFLOW]) begin
            overflow_d = 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end

        // Staying in IDLE implies an empty FIFO, so any DATA write is the push that ends idleness.
        irq_d = (state_d == ST_IDLE) && !fifo_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            div_lat_q  <= DIV_RESET;
            div_q      <= DIV_RESET;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            div_lat_q  <= div_lat_d;
            div_q      <= div_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            UART_STATUS: begin
                rdata[STAT_BUSY]     = (state_q != ST_IDLE);
                rdata[STAT_FULL]     = fifo_full;
                rdata[STAT_EMPTY]    = fifo_empty;
                rdata[STAT_OVERFLOW] = overflow_q;
                rdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
            end
            UART_DIVISOR: rdata[15:0] = div_q;
            default:      rdata = '0;
        endcase
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: bus writes queue expected frames, a serial
// monitor decodes txd cycle by cycle and compares against the queue.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   cur_div;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_busy = 1'b0;

    uart_tx_ctrl #(
        .CLK_HZ     (50_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic push_byte(input logic [7:0] b, input int div);
        exp_t e;
        e.data = b;
        e.div  = div;
        exp_q.push_back(e);
        bus_write(2'd0, {24'h0, b});
    endtask

    task automatic wait_drain(input int budget);
        int waited = 0;
        while ((exp_q.size() != 0 || mon_busy) && waited < budget) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    // Serial monitor: sample txd on every falling clock edge, one full frame at a time.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                int         div;
                int         bad;
                logic [7:0] exp_data;
                logic [7:0] recon;
                bit         aborted;
                exp_t       e;
                mon_busy = 1'b1;
                div      = (exp_q.size() > 0) ? exp_q[0].div : cur_div;
                exp_data = (exp_q.size() > 0) ? exp_q[0].data : 8'h00;
                start_q.push_back(cyc);
                bad      = 0;
                recon    = 8'h00;
                aborted  = 1'b0;
                for (int s = 0; s < 10 * div; s++) begin
                    int   b;
                    logic exp_bit;
                    if (s > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = s / div;
                    exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_data[b-1];
                    if (txd !== exp_bit) bad++;
                    if (b >= 1 && b <= 8 && (s % div) == div / 2) recon[b-1] = txd;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame got=0x%02h exp=none (cycle %0d)", recon, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", {24'h0, recon}, {24'h0, e.data});
                        check("frame_shape_bad_samples", bad, 0);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] r;
        int          e0;
        int          lows;

        reset   = 1'b1;
        we      = 1'b0;
        addr    = 2'd0;
        wdata   = '0;
        cur_div = 434;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        bus_read(2'd1, r); check("status_reset", r, 32'h004);
        check("txd_reset", {31'h0, txd}, 32'h1);
        check("irq_reset", {31'h0, irq}, 32'h1);
        bus_read(2'd2, r); check("divisor_reset", r, 32'd434);
        bus_read(2'd0, r); check("data_reads_zero", r, 32'h0);
        bus_read(2'd3, r); check("reserved_reads_zero", r, 32'h0);

        // Single frame 0x55 at divisor 4
        bus_write(2'd2, 32'd4);
        cur_div = 4;
        bus_read(2'd2, r); check("divisor_4", r, 32'd4);
        start_q.delete();
        push_byte(8'h55, 4);
        e0 = cyc;
        bus_read(2'd1, r); check("status_after_push", r, 32'h010);
        check("irq_after_push", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        bus_read(2'd1, r); check("status_after_pop", r, 32'h005);
        check("txd_start_bit", {31'h0, txd}, 32'h0);
        wait_drain(100);
        check("frame_count_55", start_q.size(), 1);
        if (start_q.size() >= 1) check("start_latency", start_q[0], e0 + 1);
        @(posedge clk); #1;
        bus_read(2'd1, r); check("status_idle_after_55", r, 32'h004);
        check("irq_idle_after_55", {31'h0, irq}, 32'h1);

        // Three frames back-to-back
        start_q.delete();
        push_byte(8'h41, 4);
        push_byte(8'h42, 4);
        push_byte(8'h43, 4);
        bus_read(2'd1, r); check("count_frame1", r, 32'h021);
        repeat (40) @(posedge clk); #1;
        bus_read(2'd1, r); check("count_frame2", r, 32'h011);
        repeat (40) @(posedge clk); #1;
        bus_read(2'd1, r); check("count_frame3", r, 32'h005);
        wait_drain(100);
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() >= 3) begin
            check("b2b_gap1", start_q[1] - start_q[0], 40);
            check("b2b_gap2", start_q[2] - start_q[1], 40);
        end

        // Overflow: one frame in flight, then 17 writes into the 16-entry FIFO
        @(posedge clk); #1;
        push_byte(8'hA0, 4);
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) push_byte(8'(i), 4);
            else         bus_write(2'd0, 32'(i));
        end
        bus_read(2'd1, r); check("status_overflow", r, 32'h10B);
        check("irq_while_busy", {31'h0, irq}, 32'h0);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, r); check("status_overflow_cleared", r, 32'h103);
        wait_drain(800);
        @(posedge clk); #1;
        bus_read(2'd1, r); check("status_idle_after_overflow", r, 32'h004);

        // Divisor clamp and change mid-frame
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, r); check("divisor_clamp_0", r, 32'd2);
        bus_write(2'd2, 32'd4);
        cur_div = 4;
        start_q.delete();
        push_byte(8'h3C, 4);
        push_byte(8'hC3, 8);
        repeat (10) @(posedge clk); #1;
        bus_write(2'd2, 32'd8);
        cur_div = 8;
        bus_read(2'd2, r); check("divisor_8", r, 32'd8);
        wait_drain(200);
        check("divchange_frames", start_q.size(), 2);
        if (start_q.size() >= 2) check("divchange_gap", start_q[1] - start_q[0], 40);

        // Asynchronous reset in the middle of a data bit
        @(posedge clk); #1;
        bus_write(2'd0, 32'h00);
        bus_write(2'd0, 32'h5A);
        bus_write(2'd0, 32'hA5);
        repeat (20) @(posedge clk); #1;
        check("txd_before_reset", {31'h0, txd}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("txd_async_reset", {31'h0, txd}, 32'h1);
        repeat (3) @(posedge clk); #1;
        reset   = 1'b0;
        cur_div = 434;
        bus_read(2'd1, r); check("status_after_reset", r, 32'h004);
        bus_read(2'd2, r); check("divisor_after_reset", r, 32'd434);
        check("irq_after_reset", {31'h0, irq}, 32'h1);
        lows = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check("txd_idle_after_reset", lows, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
